// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor: overlay modes,
// default colour key and blink rate, and packed-colour slice addressing.
package compositor_pkg;

  typedef enum logic [1:0] {
    OVL_NONE = 2'd0,
    OVL_WIN  = 2'd1,
    OVL_LOSE = 2'd2
  } overlay_mode_t;

  localparam logic [7:0] DEF_TRANSP_KEY = 8'hFF;
  localparam int         DEF_BLINK_LOG2 = 5;

  // Low bit of layer k's colour inside the packed layerRGB bus.
  function automatic int layer_slice_lo(input int k, input int rgb_w);
    return k * rgb_w;
  endfunction

endpackage

// File: rtl/priority_pick.sv
// Lowest-index-wins priority encoder: returns the index of the first set
// request bit and whether any bit was set at all.
module priority_pick #(
  parameter int NUM_LAYERS = 12,
  parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0] req,
  output logic [IDX_W-1:0]      idx,
  output logic                  found
);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise the untaken paths infer a latch.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan from the top so the lowest set index is the last one written.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: priority/transparency/enable select in stage 1,
// blinking win/lose overlay in stage 2, plus per-frame player collision latch.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int               NUM_LAYERS = 12,
  parameter int               RGB_W      = 8,
  parameter int               TRANSP_EN  = 1,
  parameter logic [RGB_W-1:0] TRANSP_KEY = DEF_TRANSP_KEY,
  parameter int               BLINK_LOG2 = DEF_BLINK_LOG2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            backGroundRGB,
  input  logic [1:0]                  overlayMode,
  input  logic [1:0]                  overlayDrawingRequest,
  input  logic [2*RGB_W-1:0]          overlayRGB,
  input  logic                        cfgWe,
  input  logic [NUM_LAYERS-1:0]       cfgEnable,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [NUM_LAYERS-1:0]       collision,
  output logic                        collisionValid,
  output logic                        blinkPhase
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [NUM_LAYERS-1:0] enable_mask;
  logic [NUM_LAYERS-1:0] eff;
  logic [NUM_LAYERS-1:0] hits;
  logic [NUM_LAYERS-1:0] acc;
  logic [RGB_W-1:0]      layer_color [NUM_LAYERS];
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic [RGB_W-1:0]      pick_rgb;

  logic [RGB_W-1:0]      s1_rgb;
  logic [RGB_W-1:0]      s1_bg;
  logic [1:0]            s1_ovl_req;
  logic [RGB_W-1:0]      s1_ovl_win;
  logic [RGB_W-1:0]      s1_ovl_lose;
  overlay_mode_t         s1_mode;

  always_comb begin
    eff         = '0;
    layer_color = '{default: '0};
    for (int k = 0; k < NUM_LAYERS; k++) begin
      layer_color[k] = layerRGB[layer_slice_lo(k, RGB_W) +: RGB_W];
      eff[k] = layerDrawingRequest[k] & enable_mask[k]
             & !((TRANSP_EN != 0) && (layer_color[k] == TRANSP_KEY));
    end
  end

  // Layer 0 is the player; it never collides with itself.
  assign hits = {eff[NUM_LAYERS-1:1] & {(NUM_LAYERS-1){eff[0]}}, 1'b0};

  priority_pick #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req   (eff),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign pick_rgb = pick_found ? layer_color[pick_idx] : backGroundRGB;

  // NOTE: sequential state is assigned with <= only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_mask <= '1;
    end else if (cfgWe) begin
      enable_mask <= cfgEnable;
    end
  end

  // Stage 1: winning layer colour plus everything stage 2 needs, aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rgb      <= '0;
      s1_bg       <= '0;
      s1_ovl_req  <= '0;
      s1_ovl_win  <= '0;
      s1_ovl_lose <= '0;
      s1_mode     <= OVL_NONE;
    end else begin
      s1_rgb      <= pick_rgb;
      s1_bg       <= backGroundRGB;
      s1_ovl_req  <= overlayDrawingRequest;
      s1_ovl_win  <= overlayRGB[RGB_W-1:0];
      s1_ovl_lose <= overlayRGB[2*RGB_W-1:RGB_W];
      if (overlayMode == OVL_WIN)       s1_mode <= OVL_WIN;
      else if (overlayMode == OVL_LOSE) s1_mode <= OVL_LOSE;
      else                              s1_mode <= OVL_NONE;
    end
  end

  // Stage 2: an active overlay hides all layers, showing only its colour
  // (when visible) or the background.
  always_ff @(posedge clk) begin
    if (reset) begin
      RGBOut <= '0;
    end else begin
      case (s1_mode)
        OVL_WIN:  RGBOut <= (s1_ovl_req[0] && blinkPhase) ? s1_ovl_win  : s1_bg;
        OVL_LOSE: RGBOut <= (s1_ovl_req[1] && blinkPhase) ? s1_ovl_lose : s1_bg;
        default:  RGBOut <= s1_rgb;
      endcase
    end
  end

  // Hits on the frame-start pixel still belong to the frame being closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc            <= '0;
      collision      <= '0;
      collisionValid <= 1'b0;
    end else begin
      collisionValid <= startOfFrame;
      if (startOfFrame) begin
        collision <= acc | hits;
        acc       <= '0;
      end else begin
        acc <= acc | hits;
      end
    end
  end

  generate
    if (BLINK_LOG2 == 0) begin : g_blink_every
      always_ff @(posedge clk) begin
        if (reset)             blinkPhase <= 1'b1;
        else if (startOfFrame) blinkPhase <= ~blinkPhase;
      end
    end else begin : g_blink_cnt
      logic [BLINK_LOG2-1:0] blink_cnt;
      always_ff @(posedge clk) begin
        if (reset) begin
          blink_cnt  <= '0;
          blinkPhase <= 1'b1;
        end else if (startOfFrame) begin
          blink_cnt <= blink_cnt + 1'b1;
          if (&blink_cnt) blinkPhase <= ~blinkPhase;
        end
      end
    end
  endgenerate

endmodule
